// File: rtl/uart_pkg.sv
// State encoding and line levels for the UART frame transmitter.
// Build option UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Frame handshake and serial-line signals between a frame source and the transmitter.
interface uart_tx_frame_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_out;
    logic              tx_busy;
    logic              tx_done;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_out, tx_busy, tx_done
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_out, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: one-cycle bit_tick every CLK_DIV cycles while enabled,
// realigned to zero by restart so the first bit of a frame is full length.
module uart_baud_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic bit_tick
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (restart || !enable || (cnt_q == CNT_LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bit_tick = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start, DATA_W data bits, optional parity, STOP_BITS stop bits.
// Parity bit and PARITY state exist only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 16,
    parameter int STOP_BITS  = 1,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_frame_if.slave  bus
);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] sreg_q;
    logic [IDX_W-1:0]  bit_idx_q;
    logic              stop_idx_q;
    logic              done_q;
    logic              accept;
    logic              bit_tick;
    logic              last_stop;
    logic              line;

    assign accept    = bus.tx_valid && bus.tx_ready;
    assign last_stop = (STOP_BITS == 1) || stop_idx_q;

    uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk      (clk),
        .reset    (reset),
        .enable   (state_q != ST_IDLE),
        .restart  (accept),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept) state_d = ST_START;
            ST_START:  if (bit_tick) state_d = ST_DATA;
`ifdef UART_TX_PARITY_EN
            ST_DATA:   if (bit_tick && (bit_idx_q == DATA_LAST)) state_d = ST_PARITY;
            ST_PARITY: if (bit_tick) state_d = ST_STOP;
`else
            ST_DATA:   if (bit_tick && (bit_idx_q == DATA_LAST)) state_d = ST_STOP;
`endif
            ST_STOP:   if (bit_tick && last_stop) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Data is shifted toward the output end so the line always reads a fixed bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg_q     <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == ST_STOP) && bit_tick && last_stop;
            if (accept) begin
                sreg_q     <= bus.tx_data;
                bit_idx_q  <= '0;
                stop_idx_q <= 1'b0;
            end else if ((state_q == ST_DATA) && bit_tick) begin
                if (MSB_FIRST != 0) begin
                    sreg_q <= {sreg_q[DATA_W-2:0], 1'b0};
                end else begin
                    sreg_q <= {1'b0, sreg_q[DATA_W-1:1]};
                end
                bit_idx_q <= (bit_idx_q == DATA_LAST) ? '0 : bit_idx_q + IDX_W'(1);
            end else if ((state_q == ST_STOP) && bit_tick) begin
                stop_idx_q <= !last_stop;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= (^bus.tx_data) ^ (PARITY_ODD != 0);
        end
    end
`else
    wire unused_parity_odd = (PARITY_ODD != 0);
`endif

    always_comb begin
        line = IDLE_LEVEL;
        case (state_q)
            ST_START:  line = START_LEVEL;
            ST_DATA:   line = (MSB_FIRST != 0) ? sreg_q[DATA_W-1] : sreg_q[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: line = parity_q;
`endif
            default:   line = IDLE_LEVEL;
        endcase
    end

    assign bus.tx_out   = line;
    assign bus.tx_ready = (state_q == ST_IDLE);
    assign bus.tx_busy  = (state_q != ST_IDLE);
    assign bus.tx_done  = done_q;

endmodule
